diff_scan_ctrl: RTL

DIFF_SCAN_CTRL -- requirements
Module: diff_scan_ctrl

---
 rtl/diff_pkg.sv | 20 ++
 rtl/diff_scan_ctrl_lowbit_enc.sv | 25 ++
 rtl/diff_scan_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/diff_pkg.sv
// Shared definitions for the differing-bit scanner: FSM encoding and
// bit-position width derivation.
package diff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    // Number of bits needed to index one bit of a WIDTH-bit word.
    function automatic int pos_width(input int width);
        return $clog2(width);
    endfunction

    localparam int POS_W = pos_width(DEFAULT_WIDTH);

endpackage

// File: rtl/diff_scan_ctrl_lowbit_enc.sv
// Combinational lowest-set-bit encoder: index of the least significant 1
// in vec, plus a flag telling whether any bit is set at all.
module lowbit_enc
    import diff_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int POS_W = pos_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [POS_W-1:0] idx,
    output logic             nonzero
);

    // Walk from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx     = '0;
        nonzero = |vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/diff_scan_ctrl.sv
// Differing-bit scanner: latches a XOR b on start and hands out the
// indices of the set bits in ascending order over a valid/ready port,
// then pulses done and reports how many positions were accepted.
module diff_scan_ctrl
    import diff_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int POS_W = pos_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             pos_valid,
    output logic [POS_W-1:0] pos,
    input  logic             pos_ready,
    output logic             done,
    output logic [POS_W:0]   count,
    output logic             equal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [POS_W:0]   count_q, count_d;
    logic             equal_q, equal_d;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mask_clr;
    logic [POS_W-1:0] low_idx;
    logic             low_nz;

    assign diff = a ^ b;

    lowbit_enc #(
        .WIDTH (WIDTH)
    ) u_lowbit_enc (
        .vec     (mask_q),
        .idx     (low_idx),
        .nonzero (low_nz)
    );

    // Mask with the currently offered bit removed, used on acceptance.
    always_comb begin
        mask_clr          = mask_q;
        mask_clr[low_idx] = 1'b0;
    end

    // Next-state and output decode; everything holds unless a case moves it.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        count_d   = count_q;
        equal_d   = equal_q;
        busy      = (state_q != ST_IDLE);
        pos_valid = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = diff;
                    count_d = '0;
                    equal_d = 1'b0;
                    state_d = (|diff) ? ST_SCAN : ST_DONE;
                end
            end
            ST_SCAN: begin
                // The mask is never empty while scanning; low_nz just
                // guards against an inconsistent state.
                pos_valid = low_nz;
                if (low_nz && pos_ready) begin
                    mask_d  = mask_clr;
                    count_d = count_q + (POS_W + 1)'(1);
                    if (mask_clr == '0) begin
                        state_d = ST_DONE;
                    end
                end else if (!low_nz) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                equal_d = (count_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset takes effect immediately and aborts any scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            count_q <= '0;
            equal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            equal_q <= equal_d;
        end
    end

    assign pos   = low_idx;
    assign count = count_q;
    assign equal = equal_q;

endmodule
